// File: rtl/iob_ram_dp_be_arb.sv
// Round-robin arbiter sharing one byte-enable RAM port among N_REQ requesters,
// with an optional one-time zero-clear of the whole RAM after reset.
module iob_ram_dp_be_arb #(
  parameter int N_REQ      = 2,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int INIT_CLEAR = 1
) (
  input  logic                       clk_i,
  input  logic                       arst_n_i,
  input  logic [N_REQ-1:0]           req_valid_i,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr_i,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata_i,
  input  logic [N_REQ*DATA_W/8-1:0]  req_wstrb_i,
  output logic [N_REQ-1:0]           req_ready_o,
  output logic [N_REQ-1:0]           req_rvalid_o,
  output logic [DATA_W-1:0]          req_rdata_o,
  output logic                       init_done_o,
  output logic                       ram_en_o,
  output logic [DATA_W/8-1:0]        ram_we_o,
  output logic [ADDR_W-1:0]          ram_addr_o,
  output logic [DATA_W-1:0]          ram_d_o,
  input  logic [DATA_W-1:0]          ram_d_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;

  state_t             state_r;
  state_t             stateNext_s;
  logic               live_r;
  logic [ADDR_W-1:0]  clrCnt_r;
  logic [IDX_W-1:0]   ptr_r;
  logic [IDX_W-1:0]   winner_s;
  logic [IDX_W-1:0]   nextPtr_s;
  logic               found_s;
  logic               grant_s;
  logic [STRB_W-1:0]  winStrb_s;
  logic               pend_r;
  logic [IDX_W-1:0]   pendIdx_r;
  logic [DATA_W-1:0]  rdataHold_r;

  // Round-robin winner search: first valid requester starting at ptr_r.
  always_comb begin
    int         cand;
    logic [IDX_W-1:0] candIdx;
    found_s  = 1'b0;
    winner_s = '0;
    cand     = 0;
    candIdx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand    = (int'(ptr_r) + k) % N_REQ;
      candIdx = IDX_W'(cand);
      if (!found_s && req_valid_i[candIdx]) begin
        found_s  = 1'b1;
        winner_s = candIdx;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // RAM port mux (clear engine or granted requester) and next-state logic.
  always_comb begin
    req_ready_o = '0;
    ram_en_o    = 1'b0;
    ram_we_o    = '0;
    ram_addr_o  = '0;
    ram_d_o     = '0;
    grant_s     = 1'b0;
    stateNext_s = state_r;
    winStrb_s   = req_wstrb_i[winner_s*STRB_W +: STRB_W];
    if (live_r) begin
      case (state_r)
        ST_CLEAR: begin
          ram_en_o   = 1'b1;
          ram_we_o   = '1;
          ram_addr_o = clrCnt_r;
          ram_d_o    = '0;
          if (clrCnt_r == {ADDR_W{1'b1}}) begin
            stateNext_s = ST_RUN;
          end else begin
            stateNext_s = ST_CLEAR;
          end
        end
        ST_RUN: begin
          if (found_s) begin
            grant_s               = 1'b1;
            req_ready_o[winner_s] = 1'b1;
            ram_en_o              = 1'b1;
            ram_we_o              = winStrb_s;
            ram_addr_o            = req_addr_i[winner_s*ADDR_W +: ADDR_W];
            ram_d_o               = req_wdata_i[winner_s*DATA_W +: DATA_W];
          end else begin
            grant_s = 1'b0;
          end
        end
        default: stateNext_s = RESET_STATE;
      endcase
    end else begin
      stateNext_s = state_r;
    end
  end

  // Pointer advance past the winner, wrapping at N_REQ.
  always_comb begin
    if (winner_s == IDX_W'(N_REQ - 1)) begin
      nextPtr_s = '0;
    end else begin
      nextPtr_s = winner_s + IDX_W'(1);
    end
  end

  // State, clear counter and a one-cycle arming flag so nothing drives the RAM during reset.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_r  <= RESET_STATE;
      clrCnt_r <= '0;
      live_r   <= 1'b0;
    end else begin
      live_r  <= 1'b1;
      state_r <= stateNext_s;
      if (live_r && (state_r == ST_CLEAR)) begin
        clrCnt_r <= clrCnt_r + ADDR_W'(1);
      end else begin
        clrCnt_r <= clrCnt_r;
      end
    end
  end

  // Arbitration pointer and read-response tracking.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      ptr_r       <= '0;
      pend_r      <= 1'b0;
      pendIdx_r   <= '0;
      rdataHold_r <= '0;
    end else begin
      if (grant_s) begin
        ptr_r <= nextPtr_s;
      end else begin
        ptr_r <= ptr_r;
      end
      pend_r    <= grant_s && (winStrb_s == '0);
      pendIdx_r <= grant_s ? winner_s : pendIdx_r;
      if (pend_r) begin
        rdataHold_r <= ram_d_i;
      end else begin
        rdataHold_r <= rdataHold_r;
      end
    end
  end

  // Read data comes straight from the RAM in the response cycle, held otherwise.
  always_comb begin
    req_rvalid_o = '0;
    if (pend_r) begin
      req_rvalid_o[pendIdx_r] = 1'b1;
      req_rdata_o             = ram_d_i;
    end else begin
      req_rdata_o = rdataHold_r;
    end
  end

  assign init_done_o = (state_r == ST_RUN);

endmodule

// File: doc/iob_ram_dp_be_arb.md
Name: iob_ram_dp_be_arb

Overview:
- Shares one port of a byte-enable dual-port RAM between N_REQ requesters using round-robin arbitration.
- Performs a one-time optional zero-clear of the whole RAM after reset.
- Returns read data with fixed 1-cycle latency.
- Sits between CPU/DMA native-interface masters and one RAM port (A or B); the other RAM port stays free for a separate master.

Parameters:
- N_REQ, 2: number of requesters (2..8).
- ADDR_W, 10: RAM address width; depth 2**ADDR_W words.
- DATA_W, 32: data width, multiple of 8.
- INIT_CLEAR, 1: 1 = zero the whole RAM after reset before accepting requests; 0 = skip.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- arst_n_i  in  1  asynchronous active-low reset.
- req_valid_i  in  N_REQ  per-requester request valid.
- req_addr_i  in  N_REQ*ADDR_W  word address, requester i at [i*ADDR_W+:ADDR_W].
- req_wdata_i  in  N_REQ*DATA_W  write data.
- req_wstrb_i  in  N_REQ*DATA_W/8  byte strobes; all-zero = read.
- req_ready_o  out  N_REQ  request accepted this cycle.
- req_rvalid_o  out  N_REQ  read data valid for requester i.
- req_rdata_o  out  DATA_W  shared read data, qualified by req_rvalid_o.
- init_done_o  out  1  clear finished, arbiter serving.
- ram_en_o  out  1  RAM port enable.
- ram_we_o  out  DATA_W/8  RAM byte write enables.
- ram_addr_o  out  ADDR_W  RAM address.
- ram_d_o  out  DATA_W  RAM write data.
- ram_d_i  in  DATA_W  RAM read data, registered in the RAM, valid 1 cycle after en.

Behaviour:
- Reset values:
  - State = CLEAR if INIT_CLEAR=1, else RUN.
  - Clear counter = 0; round-robin pointer = 0; pending-read flag = 0.
  - init_done_o = !INIT_CLEAR.
  - req_ready_o and req_rvalid_o = 0.
  - ram_en_o = 0, ram_we_o = 0.
- CLEAR state:
  - Every cycle: ram_en_o=1, ram_we_o=all ones, ram_addr_o=counter, ram_d_o=0.
  - Counter increments each cycle.
  - After the write at address 2**ADDR_W-1 (exactly 2**ADDR_W cycles), go to RUN and set init_done_o=1 on the next cycle.
  - req_ready_o held at 0 throughout CLEAR.
- RUN state:
  - Winner = first i with req_valid_i[i]=1, scanning ptr, ptr+1, ... mod N_REQ.
  - Grant is combinational in the same cycle: req_ready_o[winner]=1, all other ready bits = 0.
  - RAM signals driven from the winner: ram_en_o=1, ram_we_o=wstrb, ram_addr_o=addr, ram_d_o=wdata.
  - With no valid requester: ram_en_o=0, ram_we_o=0, ptr unchanged.
  - On every grant, ptr <= (winner+1) mod N_REQ.
  - Throughput: one access per cycle across all requesters. A requester that is the sole valid one is granted every cycle.
- Read path:
  - An accepted read (wstrb=0) registers the requester index and sets the pending flag.
  - Next cycle: req_rvalid_o[index]=1 for exactly one cycle, and req_rdata_o=ram_d_i.
  - When no rvalid is asserted, req_rdata_o holds its last value (content is don't-care).
  - Back-to-back reads are pipelined: the grant in cycle n+1 overlaps the rvalid for cycle n.
- Writes: one cycle, no response. Partial strobes are passed unchanged, so the RAM merges the bytes.
- Requester rules:
  - Addr/wdata/wstrb must stay stable while valid=1 and ready=0.
  - Deasserting valid before ready is permitted; the request is then simply not serviced.
- Boundaries:
  - Counter wraps from 2**ADDR_W-1 only by the transition to RUN; there is no second clear.
  - Reset asserted mid-CLEAR or mid-read: state returns to reset values asynchronously, any pending rvalid is dropped, and the clear restarts at address 0.
  - Requests asserted during CLEAR are held off, then arbitrated normally starting from ptr=0.
  - N_REQ=1: ptr is constant 0.

Test Plan:
- Clear: INIT_CLEAR=1, ADDR_W=4, release reset -> ram_we_o=0xF for 16 consecutive cycles, addresses 0..15, data 0; init_done_o rises the cycle after address 15; a later read of address 7 returns 0x00000000.
- Fairness: N_REQ=2, both requesters hold valid reading addresses 1 and 2 -> grants alternate 0,1,0,1 from ptr=0; each rvalid appears 1 cycle after its grant with the matching data.
- Streaming: only requester 1 valid, reading addresses 0..3 on consecutive cycles -> ready=1 every cycle; rvalid[1] high for 4 consecutive cycles returning the 4 words in order.
- Byte strobes: write 0xAABBCCDD with wstrb=0xF to address 5, then 0x11223344 with wstrb=0x3, then read address 5 -> 0xAABB3344.
- Mid-clear reset: pull arst_n_i low at clear address 9 -> outputs zero immediately; after release, the clear restarts at 0 and completes 16 writes.
- Hold-off: requester 0 valid from the first cycle after reset -> ready stays 0 until init_done_o=1, then the request is granted in the first RUN cycle.
